// File: rtl/sram_like_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_like_arbiter_pkg                                           |
// | Brief    : Shared size encodings, channel ids and width helpers.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package sram_like_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int CH_INST = 0;
    localparam int CH_DATA = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // A single channel still needs a one-bit id so the FIFO has a real width.
    function automatic int id_width(input int num_ch);
        return (num_ch > 1) ? clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_id_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_id_fifo                                                    |
// | Brief    : In-order FIFO of granted channel ids for outstanding requests.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sram_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_id,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_id;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_like_arbiter                                               |
// | Brief    : Round-robin merge of N SRAM-like masters onto one slave port.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              m_req,
    input  logic [NUM_CH-1:0]              m_wr,
    input  logic [2*NUM_CH-1:0]            m_size,
    input  logic [ADDR_W*NUM_CH-1:0]       m_addr,
    input  logic [(DATA_W/8)*NUM_CH-1:0]   m_wstrb,
    input  logic [DATA_W*NUM_CH-1:0]       m_wdata,
    output logic [NUM_CH-1:0]              m_addr_ok,
    output logic [NUM_CH-1:0]              m_data_ok,
    output logic [DATA_W-1:0]              m_rdata,
    output logic                           s_req,
    output logic                           s_wr,
    output logic [1:0]                     s_size,
    output logic [ADDR_W-1:0]              s_addr,
    output logic [DATA_W/8-1:0]            s_wstrb,
    output logic [DATA_W-1:0]              s_wdata,
    input  logic                           s_addr_ok,
    input  logic                           s_data_ok,
    input  logic [DATA_W-1:0]              s_rdata,
    output logic                           err_orphan
);
    localparam int STRB_W = DATA_W / 8;
    localparam int ID_W   = id_width(NUM_CH);

    logic [ID_W-1:0] r_rr_ptr;
    logic            r_hold;
    logic [ID_W-1:0] r_hold_id;
    logic            r_err_orphan;
    logic [ID_W-1:0] w_rr_grant;
    logic [ID_W-1:0] w_grant;
    logic [ID_W-1:0] w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_resp;

    function automatic int wrap_ch(input int v);
        return (v >= NUM_CH) ? v - NUM_CH : v;
    endfunction

    // Walk offsets from far to near so the nearest requester after the pointer wins.
    always_comb begin
        w_rr_grant = r_rr_ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (c == wrap_ch(int'(r_rr_ptr) + i) && m_req[c]) w_rr_grant = ID_W'(c);
            end
        end
    end

    // A stalled request keeps its grant so the slave sees stable fields.
    assign w_grant  = r_hold ? r_hold_id : w_rr_grant;
    assign s_req    = !reset && (|m_req) && !w_full;
    assign w_accept = s_req && s_addr_ok;
    assign w_resp   = !reset && s_data_ok && !w_empty;
    assign m_rdata  = s_rdata;
    assign err_orphan = r_err_orphan;

    always_comb begin
        s_wr      = 1'b0;
        s_size    = '0;
        s_addr    = '0;
        s_wstrb   = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(w_grant) == c) begin
                s_wr    = m_wr[c];
                s_size  = m_size[c*2 +: 2];
                s_addr  = m_addr[c*ADDR_W +: ADDR_W];
                s_wstrb = m_wstrb[c*STRB_W +: STRB_W];
                s_wdata = m_wdata[c*DATA_W +: DATA_W];
            end
            m_addr_ok[c] = w_accept && (int'(w_grant) == c);
            m_data_ok[c] = w_resp && (int'(w_head) == c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_hold       <= 1'b0;
            r_hold_id    <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_hold    <= s_req && !s_addr_ok;
            r_hold_id <= w_grant;
            if (w_accept) r_rr_ptr <= ID_W'(wrap_ch(int'(w_grant) + 1));
            if (s_data_ok && w_empty) r_err_orphan <= 1'b1;
        end
    end

    sram_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_push    (w_accept),
        .i_push_id (w_grant),
        .i_pop     (w_resp),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_head    (w_head)
    );

    a_master_holds_req : assert property (@(posedge clk) disable iff (reset)
        (s_req && !s_addr_ok) |=> (m_req[r_hold_id] && $stable(s_addr)));

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_like_arbiter                                            |
// | Brief    : Directed and random bench with a queue-based reference model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int MO  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    m_req, m_wr, m_addr_ok, m_data_ok;
    logic [2*NCH-1:0]  m_size;
    logic [AW*NCH-1:0] m_addr;
    logic [SW*NCH-1:0] m_wstrb;
    logic [DW*NCH-1:0] m_wdata;
    logic [DW-1:0]     m_rdata, s_rdata, s_wdata;
    logic              s_req, s_wr, s_addr_ok, s_data_ok, err_orphan;
    logic [1:0]        s_size;
    logic [AW-1:0]     s_addr;
    logic [SW-1:0]     s_wstrb;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int             exp_q[$];
    int             exp_rr;
    int             exp_held;
    bit             exp_orphan;
    int             exp_grant;
    int             last_acc;
    bit             exp_sreq;
    logic [NCH-1:0] exp_addr_ok, exp_data_ok;
    logic           ch_wr[NCH];
    logic [1:0]     ch_size[NCH];
    logic [AW-1:0]  ch_addr[NCH];
    logic [SW-1:0]  ch_strb[NCH];
    logic [DW-1:0]  ch_data[NCH];

    always #5 clk = ~clk;

    sram_like_arbiter #(
        .NUM_CH (NCH), .ADDR_W (AW), .DATA_W (DW), .MAX_OUT (MO)
    ) dut (
        .clk (clk), .reset (reset),
        .m_req (m_req), .m_wr (m_wr), .m_size (m_size), .m_addr (m_addr),
        .m_wstrb (m_wstrb), .m_wdata (m_wdata),
        .m_addr_ok (m_addr_ok), .m_data_ok (m_data_ok), .m_rdata (m_rdata),
        .s_req (s_req), .s_wr (s_wr), .s_size (s_size), .s_addr (s_addr),
        .s_wstrb (s_wstrb), .s_wdata (s_wdata),
        .s_addr_ok (s_addr_ok), .s_data_ok (s_data_ok), .s_rdata (s_rdata),
        .err_orphan (err_orphan)
    );

    task automatic set_ch(input int c, input logic wr, input logic [1:0] sz,
                          input logic [AW-1:0] a, input logic [SW-1:0] st, input logic [DW-1:0] d);
        ch_wr[c] = wr; ch_size[c] = sz; ch_addr[c] = a; ch_strb[c] = st; ch_data[c] = d;
        m_req[c] = 1'b1; m_wr[c] = wr; m_size[c*2 +: 2] = sz; m_addr[c*AW +: AW] = a;
        m_wstrb[c*SW +: SW] = st; m_wdata[c*DW +: DW] = d;
    endtask

    task automatic model_reset();
        exp_q.delete(); exp_rr = 0; exp_held = -1; exp_orphan = 0;
    endtask

    function automatic int model_grant();
        if (exp_held >= 0) return exp_held;
        for (int i = 0; i < NCH; i++) begin
            if (m_req[(exp_rr + i) % NCH]) return (exp_rr + i) % NCH;
        end
        return -1;
    endfunction

    task automatic eval_cycle(input bit aok, input bit dok, input logic [DW-1:0] rd);
        s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
        @(negedge clk);
        exp_grant   = model_grant();
        exp_sreq    = (m_req != '0) && (exp_q.size() < MO);
        exp_addr_ok = '0;
        exp_data_ok = '0;
        if (exp_sreq && aok) exp_addr_ok[exp_grant] = 1'b1;
        if (dok && exp_q.size() > 0) exp_data_ok[exp_q[0]] = 1'b1;
    endtask

    task automatic advance();
        last_acc = -1;
        if (s_data_ok && exp_q.size() == 0) exp_orphan = 1;
        if (exp_data_ok != '0) void'(exp_q.pop_front());
        if (exp_addr_ok != '0) begin
            exp_q.push_back(exp_grant);
            exp_rr   = (exp_grant + 1) % NCH;
            last_acc = exp_grant;
        end
        exp_held = (exp_sreq && !s_addr_ok) ? exp_grant : -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; m_req = '1; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = '0;
        @(posedge clk); @(negedge clk);
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL reset_s_req: got %b want 0", s_req); end
        checks++; if (m_addr_ok !== '0) begin failures++; $display("FAIL reset_addr_ok: got %b want 000", m_addr_ok); end
        checks++; if (m_data_ok !== '0) begin failures++; $display("FAIL reset_data_ok: got %b want 000", m_data_ok); end
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL reset_orphan: got %b want 0", err_orphan); end
        @(posedge clk); #1;
        reset = 1'b0; m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        model_reset();
        eval_cycle(0, 0, '0);
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL idle_s_req: got %b want 0", s_req); end
        advance();
    endtask

    task automatic test_rr_order();
        logic [NCH-1:0] seq [4] = '{3'b001, 3'b010, 3'b001, 3'b010};
        set_ch(0, 1'b0, SZ_WORD, 32'h0000_0100, 4'hF, 32'h0);
        set_ch(1, 1'b0, SZ_WORD, 32'h0000_0110, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            eval_cycle(1, 0, '0);
            checks++; if (m_addr_ok !== seq[i]) begin failures++; $display("FAIL rr_order[%0d]: got %b want %b", i, m_addr_ok, seq[i]); end
            checks++; if (s_addr !== ((seq[i] == 3'b001) ? 32'h100 : 32'h110)) begin failures++; $display("FAIL rr_addr[%0d]: got %h", i, s_addr); end
            advance();
        end
        m_req = '0;
        for (int i = 0; i < 4; i++) begin
            eval_cycle(0, 1, 32'hA0 + i);
            checks++; if (m_data_ok !== seq[i]) begin failures++; $display("FAIL rr_resp[%0d]: got %b want %b", i, m_data_ok, seq[i]); end
            advance();
        end
    endtask

    task automatic test_read_response();
        set_ch(1, 1'b0, SZ_WORD, 32'h0000_1000, 4'h0, 32'h0);
        eval_cycle(1, 0, '0);
        checks++; if (m_addr_ok !== 3'b010) begin failures++; $display("FAIL rd_accept: got %b want 010", m_addr_ok); end
        checks++; if (s_addr !== 32'h1000 || s_wr !== 1'b0) begin failures++; $display("FAIL rd_fields: got %h/%b want 00001000/0", s_addr, s_wr); end
        advance();
        m_req = '0;
        for (int i = 0; i < 2; i++) begin
            eval_cycle(0, 0, '0);
            checks++; if (m_data_ok !== '0) begin failures++; $display("FAIL rd_early: got %b want 000", m_data_ok); end
            advance();
        end
        eval_cycle(0, 1, 32'hDEAD_BEEF);
        checks++; if (m_data_ok !== 3'b010) begin failures++; $display("FAIL rd_data_ok: got %b want 010", m_data_ok); end
        checks++; if (m_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_rdata: got %h want deadbeef", m_rdata); end
        advance();
    endtask

    task automatic test_full();
        set_ch(0, 1'b1, SZ_WORD, 32'h0000_2000, 4'hF, 32'h1111_0000);
        for (int i = 0; i < 4; i++) begin
            eval_cycle(1, 0, '0);
            checks++; if (m_addr_ok !== 3'b001) begin failures++; $display("FAIL fill[%0d]: got %b want 001", i, m_addr_ok); end
            advance();
        end
        eval_cycle(1, 0, '0);
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL full_blocks: got %b want 0", s_req); end
        advance();
        eval_cycle(1, 1, 32'h5);
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL full_with_pop: got %b want 0", s_req); end
        checks++; if (m_data_ok !== 3'b001) begin failures++; $display("FAIL full_pop: got %b want 001", m_data_ok); end
        advance();
        eval_cycle(1, 1, 32'h6);
        checks++; if (s_req !== 1'b1 || m_addr_ok !== 3'b001 || m_data_ok !== 3'b001) begin
            failures++; $display("FAIL push_pop: got req=%b aok=%b dok=%b want 1/001/001", s_req, m_addr_ok, m_data_ok); end
        advance();
        eval_cycle(1, 0, '0);
        checks++; if (m_addr_ok !== 3'b001) begin failures++; $display("FAIL refill: got %b want 001", m_addr_ok); end
        advance();
        eval_cycle(1, 0, '0);
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL full_again: got %b want 0", s_req); end
        advance();
        m_req = '0;
        for (int i = 0; i < 4; i++) begin
            eval_cycle(0, 1, '0);
            checks++; if (m_data_ok !== 3'b001) begin failures++; $display("FAIL full_drain[%0d]: got %b want 001", i, m_data_ok); end
            advance();
        end
    endtask

    task automatic test_interleave();
        int             chs [3] = '{0, 1, 0};
        logic [NCH-1:0] oh  [3] = '{3'b001, 3'b010, 3'b001};
        for (int i = 0; i < 3; i++) begin
            m_req = '0;
            set_ch(chs[i], 1'b1, SZ_HALF, 32'h3000 + 32'(i * 4), 4'h3, 32'h77 + 32'(i));
            eval_cycle(1, 0, '0);
            checks++; if (m_addr_ok !== oh[i]) begin failures++; $display("FAIL il_accept[%0d]: got %b want %b", i, m_addr_ok, oh[i]); end
            advance();
        end
        m_req = '0;
        for (int i = 0; i < 3; i++) begin
            eval_cycle(0, 1, '0);
            checks++; if (m_data_ok !== oh[i]) begin failures++; $display("FAIL il_resp[%0d]: got %b want %b", i, m_data_ok, oh[i]); end
            advance();
        end
    endtask

    task automatic test_orphan();
        eval_cycle(0, 1, 32'h99);
        checks++; if (m_data_ok !== '0) begin failures++; $display("FAIL orphan_no_resp: got %b want 000", m_data_ok); end
        advance();
        for (int i = 0; i < 3; i++) begin
            eval_cycle(0, 0, '0);
            checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky[%0d]: got %b want 1", i, err_orphan); end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        logic [NCH-1:0] wrap [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        m_req = '0;
        set_ch(1, 1'b0, SZ_BYTE, 32'h4001, 4'h1, 32'h0);
        for (int i = 0; i < 2; i++) begin eval_cycle(1, 0, '0); advance(); end
        set_ch(0, 1'b0, SZ_WORD, 32'h5000, 4'hF, 32'h0);
        set_ch(2, 1'b1, SZ_WORD, 32'h5020, 4'hF, 32'hCAFE_0002);
        reset = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
        @(negedge clk);
        checks++; if (s_req !== 1'b0 || m_addr_ok !== '0 || m_data_ok !== '0) begin
            failures++; $display("FAIL mid_reset_out: got req=%b aok=%b dok=%b want 0", s_req, m_addr_ok, m_data_ok); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        eval_cycle(0, 1, '0);
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL mid_orphan_clear: got %b want 0", err_orphan); end
        checks++; if (m_data_ok !== '0) begin failures++; $display("FAIL mid_discard: got %b want 000", m_data_ok); end
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h5000) begin failures++; $display("FAIL mid_rr_zero: got %b/%h want 1/00005000", s_req, s_addr); end
        advance();
        for (int i = 0; i < 4; i++) begin
            eval_cycle(1, 0, '0);
            if (i == 0) begin
                checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL mid_late_orphan: got %b want 1", err_orphan); end
            end
            checks++; if (m_addr_ok !== wrap[i]) begin failures++; $display("FAIL wrap[%0d]: got %b want %b", i, m_addr_ok, wrap[i]); end
            advance();
        end
        m_req = '0;
        for (int i = 0; i < 4; i++) begin
            eval_cycle(0, 1, '0);
            checks++; if (m_data_ok !== wrap[i]) begin failures++; $display("FAIL wrap_resp[%0d]: got %b want %b", i, m_data_ok, wrap[i]); end
            advance();
        end
    endtask

    task automatic test_random();
        reset = 1'b1; m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!m_req[c] && $urandom_range(0, 1) == 1)
                    set_ch(c, 1'($urandom), 2'($urandom_range(0, 2)), $urandom, 4'($urandom), $urandom);
            end
            eval_cycle(1'($urandom), ($urandom_range(0, 2) == 0), $urandom);
            checks++; if (s_req !== exp_sreq) begin failures++; $display("FAIL rnd_s_req@%0d: got %b want %b", n, s_req, exp_sreq); end
            checks++; if (m_addr_ok !== exp_addr_ok) begin failures++; $display("FAIL rnd_addr_ok@%0d: got %b want %b", n, m_addr_ok, exp_addr_ok); end
            checks++; if (m_data_ok !== exp_data_ok) begin failures++; $display("FAIL rnd_data_ok@%0d: got %b want %b", n, m_data_ok, exp_data_ok); end
            checks++; if (err_orphan !== exp_orphan) begin failures++; $display("FAIL rnd_orphan@%0d: got %b want %b", n, err_orphan, exp_orphan); end
            if (exp_data_ok != '0) begin
                checks++; if (m_rdata !== s_rdata) begin failures++; $display("FAIL rnd_rdata@%0d: got %h want %h", n, m_rdata, s_rdata); end
            end
            if (exp_sreq) begin
                checks++;
                if (s_addr !== ch_addr[exp_grant] || s_wr !== ch_wr[exp_grant] || s_size !== ch_size[exp_grant] ||
                    s_wstrb !== ch_strb[exp_grant] || s_wdata !== ch_data[exp_grant]) begin
                    failures++;
                    $display("FAIL rnd_fields@%0d: got %h/%b/%0d/%h/%h want ch%0d %h/%b/%0d/%h/%h", n, s_addr, s_wr, s_size, s_wstrb,
                             s_wdata, exp_grant, ch_addr[exp_grant], ch_wr[exp_grant], ch_size[exp_grant], ch_strb[exp_grant], ch_data[exp_grant]);
                end
            end
            advance();
            if (last_acc >= 0) m_req[last_acc] = 1'b0;
        end
    endtask

    initial begin
        m_req = '0; m_wr = '0; m_size = '0; m_addr = '0; m_wstrb = '0; m_wdata = '0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0; reset = 1'b1;
        test_reset();
        test_rr_order();
        test_read_response();
        test_full();
        test_interleave();
        test_orphan();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
